// File: rtl/correlation_controller.sv
// correlation_controller: streams a window of pixel/template sets through an external
// correlation cell and accumulates the returned I^2 and T*I products into window sums.
`default_nettype none

module correlation_controller #(
   parameter int PIXEL_SIZE    = 8,
   parameter int NUM_TEMPLATES = 10,
   parameter int WINDOW_LEN    = 64,
   parameter int CELL_LATENCY  = 1
) (
   input  logic                                           CLK,
   input  logic                                           RST_N,
   input  logic                                           start,
   input  logic                                           pix_valid,
   output logic                                           pix_ready,
   input  logic [PIXEL_SIZE-1:0]                          pix_in,
   input  logic [PIXEL_SIZE-1:0]                          tmpl_in [NUM_TEMPLATES],
   output logic [PIXEL_SIZE-1:0]                          cell_I,
   output logic [PIXEL_SIZE-1:0]                          cell_T [NUM_TEMPLATES],
   input  logic [2*PIXEL_SIZE-1:0]                        cell_I_square,
   input  logic [2*PIXEL_SIZE-1:0]                        cell_T_x_I [NUM_TEMPLATES],
   output logic                                           busy,
   output logic                                           out_valid,
   output logic [2*PIXEL_SIZE+$clog2(WINDOW_LEN)-1:0]     sum_I_sq,
   output logic [2*PIXEL_SIZE+$clog2(WINDOW_LEN)-1:0]     sum_T_x_I [NUM_TEMPLATES]
);

   localparam int ACC_W = 2*PIXEL_SIZE + $clog2(WINDOW_LEN);
   localparam int CNT_W = $clog2(WINDOW_LEN);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(WINDOW_LEN-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    pix_ready_q;
   logic                    busy_q;
   logic                    out_valid_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CELL_LATENCY:0]   tag_q;
   logic [PIXEL_SIZE-1:0]   cell_I_q;
   logic [PIXEL_SIZE-1:0]   cell_T_q [NUM_TEMPLATES];
   logic [ACC_W-1:0]        sum_I_q;
   logic [ACC_W-1:0]        sum_T_q [NUM_TEMPLATES];
   logic                    accept;

   assign accept = pix_valid & pix_ready_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (accept && (cnt_q == LAST_PIX)) state_d = DRAIN;
         DRAIN:   if (tag_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         pix_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         tag_q       <= '0;
         cell_I_q    <= '0;
         sum_I_q     <= '0;
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            cell_T_q[k] <= '0;
            sum_T_q[k]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         pix_ready_q <= (state_d == RUN);
         busy_q      <= (state_d != IDLE);
         out_valid_q <= (state_d == DONE);
         // Tag bit CELL_LATENCY lines up with the cell result of the matching accept.
         tag_q       <= {tag_q[CELL_LATENCY-1:0], accept};
         cell_I_q    <= accept ? pix_in : '0;
         for (int k = 0; k < NUM_TEMPLATES; k++) begin
            cell_T_q[k] <= accept ? tmpl_in[k] : '0;
         end
         if ((state_q == IDLE) && start) begin
            cnt_q   <= '0;
            sum_I_q <= '0;
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
               sum_T_q[k] <= '0;
            end
         end else begin
            if (accept) cnt_q <= cnt_q + CNT_W'(1);
            if (tag_q[CELL_LATENCY]) begin
               sum_I_q <= sum_I_q + ACC_W'(cell_I_square);
               for (int k = 0; k < NUM_TEMPLATES; k++) begin
                  sum_T_q[k] <= sum_T_q[k] + ACC_W'(cell_T_x_I[k]);
               end
            end
         end
      end
   end

   assign pix_ready = pix_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign cell_I    = cell_I_q;
   assign cell_T    = cell_T_q;
   assign sum_I_sq  = sum_I_q;
   assign sum_T_x_I = sum_T_q;

endmodule

`default_nettype wire
